// File: rtl/enable_pulse_gen_pkg.sv
// enable_pulse_gen_pkg: FSM state encoding, default timing constants and counter width helper.
package enable_pulse_gen_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;
  localparam int SYNC_STAGES_D   = 2;
  localparam int DB_CYCLES_D     = 16;
  localparam int REPEAT_EN_D     = 1;
  localparam int REPEAT_DELAY_D  = 64;
  localparam int REPEAT_PERIOD_D = 16;
  function automatic int cnt_w(int term);
    return term > 0 ? $clog2(term + 1) : 1;
  endfunction
endpackage

// File: rtl/enable_pulse_gen_if.sv
// enable_pulse_gen_if: raw button in, strobe/level/repeat status out.
interface enable_pulse_gen_if;
  logic btn_in;
  logic enable;
  logic btn_level;
  logic repeat_active;
  modport master (output btn_in, input enable, btn_level, repeat_active);
  modport slave (input btn_in, output enable, btn_level, repeat_active);
endinterface

// File: rtl/enable_pulse_gen_sync_debounce.sv
// enable_pulse_gen_sync_debounce: synchronises din and accepts a level change after DB_CYCLES differing samples.
module enable_pulse_gen_sync_debounce
  import enable_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int DB_CYCLES   = DB_CYCLES_D
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level
);
  localparam int CW = cnt_w(DB_CYCLES - 1);
  localparam logic [CW-1:0] DB_T = CW'(DB_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] db_cnt;
  logic sync_q;
  assign sync_q = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      db_cnt <= '0;
      level  <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], din};
      level  <= (sync_q != level && db_cnt == DB_T) ? ~level : level;
      db_cnt <= (sync_q == level || db_cnt == DB_T) ? '0 : db_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen: debounced button to one-cycle enable strobes with optional auto-repeat.
module enable_pulse_gen
  import enable_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_D,
  parameter int DB_CYCLES     = DB_CYCLES_D,
  parameter int REPEAT_EN     = REPEAT_EN_D,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_D,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_D
) (
  input logic clk,
  input logic rst_n,
  enable_pulse_gen_if.slave bus
);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_w(RMAX - 1);
  localparam logic [RW-1:0] DLY_T = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_T = RW'(REPEAT_PERIOD - 1);
  state_t state, state_d;
  logic [RW-1:0] rep_cnt, rep_cnt_d;
  logic level, btn_level, enable_q, en_d, rise, fall;
  enable_pulse_gen_sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) u_sync_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.btn_in),
    .level(level)
  );
  // btn_level re-registers the debounced level so the press strobe lands on the same edge
  assign rise = level & ~btn_level;
  assign fall = ~level & btn_level;
  always_comb begin
    state_d   = state;
    rep_cnt_d = rep_cnt;
    en_d      = 1'b0;
    if (fall) begin
      state_d   = ST_IDLE;
      rep_cnt_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_d = rise ? ST_HOLD : ST_IDLE;
          en_d    = rise;
        end
        ST_HOLD: begin
          if (rep_cnt != DLY_T) rep_cnt_d = rep_cnt + 1'b1;
          else if (REPEAT_EN != 0) begin
            state_d   = ST_REPEAT;
            rep_cnt_d = '0;
            en_d      = 1'b1;
          end
        end
        ST_REPEAT: begin
          en_d      = rep_cnt == PER_T;
          rep_cnt_d = rep_cnt == PER_T ? '0 : rep_cnt + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rep_cnt   <= '0;
      enable_q  <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_d;
      rep_cnt   <= rep_cnt_d;
      enable_q  <= en_d;
      btn_level <= level;
    end
  end
  assign bus.enable        = enable_q;
  assign bus.btn_level     = btn_level;
  assign bus.repeat_active = state == ST_REPEAT;
endmodule

// File: tb/tb_enable_pulse_gen.sv
// tb_enable_pulse_gen: scoreboard bench; expected strobe/level edges are derived from press timing.
module tb_enable_pulse_gen;
  localparam int BIG = 1 << 30;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_push = 0;
  int n_seen = 0;
  int q1[$];
  int q0[$];
  int lq[$];
  logic [3:0] cnt4 = '0;
  logic p_en = 1'b0;
  logic p_lvl = 1'b0;
  enable_pulse_gen_if bus1 ();
  enable_pulse_gen_if bus0 ();
  assign bus1.btn_in = btn;
  assign bus0.btn_in = btn;
  enable_pulse_gen #(
    .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  enable_pulse_gen #(
    .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // press sampled high from edge e0 for h edges; strobes/edges at or beyond cut are never seen
  task automatic push_press(int e0, int h, int cut);
    int t0 = e0 + 6;
    int f = e0 + h + 6;
    if (h < 4) return;
    if (t0 < cut) begin
      q1.push_back(t0);
      q0.push_back(t0);
      lq.push_back(t0);
      n_push++;
    end
    for (int t = t0 + 8; t < f && t < cut; t += 4) begin
      q1.push_back(t);
      n_push++;
    end
    if (f < cut) lq.push_back(f);
  endtask
  task automatic press(int h, int gap);
    tick();
    btn = 1'b1;
    push_press(cyc + 1, h, BIG);
    repeat (h) tick();
    btn = 1'b0;
    repeat (gap) tick();
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      p_en  = 1'b0;
      p_lvl = 1'b0;
    end else begin
      if (bus1.enable) begin
        n_seen++;
        cnt4 = cnt4 + 1'b1;
        check("strobe_rep", cyc, q1.size() != 0 ? q1.pop_front() : -1);
      end
      if (bus0.enable) check("strobe_norep", cyc, q0.size() != 0 ? q0.pop_front() : -1);
      if (bus1.btn_level != p_lvl) check("level_edge", cyc, lq.size() != 0 ? lq.pop_front() : -1);
      check("no_back_to_back", int'(bus1.enable & p_en), 0);
      p_en  = bus1.enable;
      p_lvl = bus1.btn_level;
    end
  end
  initial begin
    int e0;
    int k0;
    logic [3:0] c0;
    #2 rst_n = 1'b0;
    btn = 1'b1;
    repeat (3) begin
      tick();
      check("rst_enable", int'(bus1.enable), 0);
      check("rst_level", int'(bus1.btn_level), 0);
      check("rst_repeat", int'(bus1.repeat_active), 0);
    end
    rst_n = 1'b1;
    push_press(cyc + 1, 20, BIG);
    repeat (20) tick();
    btn = 1'b0;
    repeat (20) tick();
    press(12, 20);
    for (int i = 0; i < 8; i++) begin
      tick();
      btn = (i % 2) == 0;
    end
    press(15, 20);
    tick();
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    repeat (15) tick();
    check("glitch_level", int'(bus1.btn_level), 0);
    c0 = cnt4;
    k0 = n_push;
    tick();
    btn = 1'b1;
    e0 = cyc + 1;
    push_press(e0, 40, BIG);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cyc == e0 + 13) check("repeat_pre", int'(bus1.repeat_active), 0);
      if (cyc == e0 + 14) check("repeat_on", int'(bus1.repeat_active), 1);
    end
    btn = 1'b0;
    repeat (20) tick();
    check("repeat_off", int'(bus1.repeat_active), 0);
    check("repeat_count", n_push - k0, 9);
    check("downstream_cnt", int'(cnt4), (int'(c0) + n_push - k0) % 16);
    tick();
    btn = 1'b1;
    e0 = cyc + 1;
    push_press(e0, 100, e0 + 17);
    while (cyc < e0 + 16) tick();
    check("pre_rst_repeat", int'(bus1.repeat_active), 1);
    check("pre_rst_level", int'(bus1.btn_level), 1);
    rst_n = 1'b0;
    #1;
    check("async_enable", int'(bus1.enable), 0);
    check("async_level", int'(bus1.btn_level), 0);
    check("async_repeat", int'(bus1.repeat_active), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    push_press(cyc + 1, 20, BIG);
    repeat (20) tick();
    btn = 1'b0;
    repeat (20) tick();
    check("left_rep", q1.size(), 0);
    check("left_norep", q0.size(), 0);
    check("left_level", lq.size(), 0);
    check("strobe_total", n_seen, n_push);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
